// File: rtl/sysbus_arbiter.sv
// Round-robin arbiter and read-transaction sequencer for the shared Sysbus master port.
// Grants one requester, drives the request phase, then steers the response burst to its owner.
module sysbus_arbiter #(
   parameter int BUS_DATA_WIDTH = 64,
   parameter int BUS_TAG_WIDTH  = 13,
   parameter int NUM_REQ        = 3,
   parameter int BEATS_PER_LINE = 8
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic [NUM_REQ-1:0]                  i_req_valid,
   input  logic [NUM_REQ*BUS_DATA_WIDTH-1:0]   i_req_addr,
   input  logic [NUM_REQ*BUS_TAG_WIDTH-1:0]    i_req_tag,
   output logic [NUM_REQ-1:0]                  o_req_grant,
   output logic [NUM_REQ-1:0]                  o_resp_valid,
   output logic [BUS_DATA_WIDTH-1:0]           o_resp_data,
   output logic                                o_resp_last,
   output logic                                o_busy,
   output logic                                o_err_tag,
   output logic                                o_err_spurious,
   output logic                                o_bus_reqcyc,
   output logic [BUS_DATA_WIDTH-1:0]           o_bus_req,
   output logic [BUS_TAG_WIDTH-1:0]            o_bus_reqtag,
   input  logic                                i_bus_reqack,
   input  logic                                i_bus_respcyc,
   input  logic [BUS_DATA_WIDTH-1:0]           i_bus_resp,
   input  logic [BUS_TAG_WIDTH-1:0]            i_bus_resptag,
   output logic                                o_bus_respack
);

   // state | meaning
   // IDLE  | no transaction; round-robin grant evaluated every cycle
   // REQ   | request phase driven on the bus until bus_reqack
   // RESP  | response beats steered to the owner until the last beat
   typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int SUM_W = IDX_W + 1;
   localparam int CNT_W = (BEATS_PER_LINE > 1) ? $clog2(BEATS_PER_LINE) : 1;

   state_t                      r_state;
   logic [IDX_W-1:0]            r_rr;
   logic [IDX_W-1:0]            r_owner;
   logic [BUS_DATA_WIDTH-1:0]   r_addr;
   logic [BUS_TAG_WIDTH-1:0]    r_tag;
   logic [CNT_W-1:0]            r_cnt;
   logic                        r_reqcyc;
   logic                        r_err_tag;
   logic                        r_err_spurious;

   logic [BUS_DATA_WIDTH-1:0]   w_addr_arr [NUM_REQ];
   logic [BUS_TAG_WIDTH-1:0]    w_tag_arr  [NUM_REQ];
   logic                        w_found;
   logic [IDX_W-1:0]            w_winner;
   logic [SUM_W-1:0]            w_sum;
   logic                        w_beat;
   logic                        w_last_beat;
   logic [IDX_W-1:0]            w_rr_next;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign w_addr_arr[g] = i_req_addr[g*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
      assign w_tag_arr[g]  = i_req_tag[g*BUS_TAG_WIDTH +: BUS_TAG_WIDTH];
   end

   // Search starts at r_rr and wraps; first pending requester wins.
   always_comb begin
      w_found  = 1'b0;
      w_winner = '0;
      w_sum    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_sum = {1'b0, r_rr} + SUM_W'(k);
         if (w_sum >= SUM_W'(NUM_REQ)) w_sum = w_sum - SUM_W'(NUM_REQ);
         if (!w_found && i_req_valid[w_sum[IDX_W-1:0]]) begin
            w_found  = 1'b1;
            w_winner = w_sum[IDX_W-1:0];
         end
      end
   end

   assign w_beat      = (r_state == RESP) && i_bus_respcyc;
   assign w_last_beat = w_beat && (r_cnt == CNT_W'(BEATS_PER_LINE - 1));
   assign w_rr_next   = (r_owner == IDX_W'(NUM_REQ - 1)) ? '0 : r_owner + IDX_W'(1);

   assign o_req_grant    = (r_state == IDLE && w_found) ? (NUM_REQ'(1) << w_winner) : '0;
   assign o_resp_valid   = w_beat ? (NUM_REQ'(1) << r_owner) : '0;
   assign o_resp_data    = w_beat ? i_bus_resp : '0;
   assign o_resp_last    = w_last_beat;
   assign o_busy         = (r_state != IDLE);
   assign o_err_tag      = r_err_tag;
   assign o_err_spurious = r_err_spurious;
   assign o_bus_reqcyc   = r_reqcyc;
   assign o_bus_req      = r_reqcyc ? r_addr : '0;
   assign o_bus_reqtag   = r_reqcyc ? r_tag : '0;
   // Every beat is acknowledged: consumed in RESP, dropped as spurious otherwise.
   assign o_bus_respack  = i_bus_respcyc;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state        <= IDLE;
         r_rr           <= '0;
         r_owner        <= '0;
         r_addr         <= '0;
         r_tag          <= '0;
         r_cnt          <= '0;
         r_reqcyc       <= 1'b0;
         r_err_tag      <= 1'b0;
         r_err_spurious <= 1'b0;
      end else begin
         if (i_bus_respcyc && r_state != RESP) r_err_spurious <= 1'b1;
         case (r_state)
            IDLE: begin
               if (w_found) begin
                  r_owner  <= w_winner;
                  r_addr   <= w_addr_arr[w_winner];
                  r_tag    <= w_tag_arr[w_winner];
                  r_reqcyc <= 1'b1;
                  r_state  <= REQ;
               end
            end
            REQ: begin
               if (i_bus_reqack) begin
                  r_reqcyc <= 1'b0;
                  r_cnt    <= '0;
                  r_state  <= RESP;
               end
            end
            RESP: begin
               if (w_beat) begin
                  if (i_bus_resptag != r_tag) r_err_tag <= 1'b1;
                  if (w_last_beat) begin
                     r_cnt   <= '0;
                     r_rr    <= w_rr_next;
                     r_state <= IDLE;
                  end else begin
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
               end
            end
            default: begin
               r_reqcyc <= 1'b0;
               r_state  <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sysbus_arbiter.sv
// Directed bench for sysbus_arbiter: per-cycle vector table plus hand-built
// contention and mid-transaction reset sequences.
module tb_sysbus_arbiter;
   localparam int DW = 64, TW = 13, NR = 3, BPL = 8;
   localparam logic [DW-1:0] A0 = 64'h0A00, A1 = 64'h1000, A2 = 64'h2000;
   localparam logic [TW-1:0] T0 = 13'h00A0, T1 = 13'h1100, T2 = 13'h1220;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic [NR-1:0]    req_valid;
   logic [NR*DW-1:0] req_addr;
   logic [NR*TW-1:0] req_tag;
   logic [NR-1:0]    req_grant, resp_valid;
   logic [DW-1:0]    resp_data, bus_req, bus_resp;
   logic             resp_last, busy, err_tag, err_spurious;
   logic             bus_reqcyc, bus_reqack, bus_respcyc, bus_respack;
   logic [TW-1:0]    bus_reqtag, bus_resptag;

   sysbus_arbiter #(.BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW), .NUM_REQ(NR), .BEATS_PER_LINE(BPL)) dut (
      .clk(clk), .reset(reset),
      .i_req_valid(req_valid), .i_req_addr(req_addr), .i_req_tag(req_tag),
      .o_req_grant(req_grant), .o_resp_valid(resp_valid), .o_resp_data(resp_data),
      .o_resp_last(resp_last), .o_busy(busy), .o_err_tag(err_tag), .o_err_spurious(err_spurious),
      .o_bus_reqcyc(bus_reqcyc), .o_bus_req(bus_req), .o_bus_reqtag(bus_reqtag),
      .i_bus_reqack(bus_reqack), .i_bus_respcyc(bus_respcyc), .i_bus_resp(bus_resp),
      .i_bus_resptag(bus_resptag), .o_bus_respack(bus_respack)
   );

   typedef struct {
      logic [2:0]    rv;
      logic          ack;
      logic          rc;
      logic [DW-1:0] rd;
      logic [TW-1:0] rt;
      logic [2:0]    g;
      logic [2:0]    vld;
      logic          last;
      logic          rcyc;
      logic [DW-1:0] addr;
      logic [TW-1:0] qtag;
      logic          bsy;
      logic          rack;
      logic          et;
      logic          es;
   } vec_t;

   int checks = 0;
   int errors = 0;
   vec_t tbl[$];

   function automatic vec_t mk(input logic [2:0] rv, input logic ack, input logic rc,
                               input logic [DW-1:0] rd, input logic [TW-1:0] rt,
                               input logic [2:0] g, input logic [2:0] vld, input logic last,
                               input logic rcyc, input logic [DW-1:0] addr, input logic [TW-1:0] qtag,
                               input logic bsy, input logic rack, input logic et, input logic es);
      vec_t v;
      v.rv = rv; v.ack = ack; v.rc = rc; v.rd = rd; v.rt = rt;
      v.g = g; v.vld = vld; v.last = last; v.rcyc = rcyc; v.addr = addr; v.qtag = qtag;
      v.bsy = bsy; v.rack = rack; v.et = et; v.es = es;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic cyc(input vec_t v, input string nm);
      @(negedge clk);
      reset       = 1'b0;
      req_valid   = v.rv;
      bus_reqack  = v.ack;
      bus_respcyc = v.rc;
      bus_resp    = v.rd;
      bus_resptag = v.rt;
      #1;
      chk({nm, " req_grant"},    DW'(req_grant),    DW'(v.g));
      chk({nm, " resp_valid"},   DW'(resp_valid),   DW'(v.vld));
      chk({nm, " resp_data"},    resp_data,         (v.vld != 3'b000) ? v.rd : '0);
      chk({nm, " resp_last"},    DW'(resp_last),    DW'(v.last));
      chk({nm, " bus_reqcyc"},   DW'(bus_reqcyc),   DW'(v.rcyc));
      chk({nm, " bus_req"},      bus_req,           v.rcyc ? v.addr : '0);
      chk({nm, " bus_reqtag"},   DW'(bus_reqtag),   v.rcyc ? DW'(v.qtag) : '0);
      chk({nm, " busy"},         DW'(busy),         DW'(v.bsy));
      chk({nm, " bus_respack"},  DW'(bus_respack),  DW'(v.rack));
      chk({nm, " err_tag"},      DW'(err_tag),      DW'(v.et));
      chk({nm, " err_spurious"}, DW'(err_spurious), DW'(v.es));
   endtask

   task automatic rst_cyc();
      @(negedge clk);
      reset = 1'b1; req_valid = '0; bus_reqack = 1'b0; bus_respcyc = 1'b0;
   endtask

   // Full transaction with same-cycle reqack and gapless beats; flags expected clear.
   task automatic run_txn(input int w, input logic [2:0] rv, input logic [DW-1:0] a, input logic [TW-1:0] t);
      logic [2:0] oh;
      oh = 3'b001 << w;
      cyc(mk(rv, 0, 0, '0, '0, oh, 3'b000, 0, 0, '0, '0, 0, 0, 0, 0), $sformatf("txn%0d grant", w));
      cyc(mk(rv, 1, 0, '0, '0, 3'b000, 3'b000, 0, 1, a, t, 1, 0, 0, 0), $sformatf("txn%0d req", w));
      for (int k = 1; k <= BPL; k++)
         cyc(mk(rv, 0, 1, DW'(w*256 + k), t, 3'b000, oh, k == BPL, 0, '0, '0, 1, 1, 0, 0),
             $sformatf("txn%0d beat%0d", w, k));
   endtask

   initial begin
      req_addr = {A2, A1, A0};
      req_tag  = {T2, T1, T0};
      reset = 1'b1; req_valid = '0; bus_reqack = 1'b0; bus_respcyc = 1'b0;
      bus_resp = '0; bus_resptag = '0;

      // Single requester 1, reqack in cycle 3, gapless burst.
      tbl.push_back(mk(3'b010, 0, 0, '0, '0, 3'b010, 3'b000, 0, 0, '0, '0, 0, 0, 0, 0));
      tbl.push_back(mk(3'b000, 0, 0, '0, '0, 3'b000, 3'b000, 0, 1, A1, T1, 1, 0, 0, 0));
      tbl.push_back(mk(3'b000, 0, 0, '0, '0, 3'b000, 3'b000, 0, 1, A1, T1, 1, 0, 0, 0));
      tbl.push_back(mk(3'b000, 1, 0, '0, '0, 3'b000, 3'b000, 0, 1, A1, T1, 1, 0, 0, 0));
      for (int k = 1; k <= BPL; k++)
         tbl.push_back(mk(3'b000, 0, 1, DW'(k * 'h11), T1, 3'b000, 3'b010, k == BPL, 0, '0, '0, 1, 1, 0, 0));
      tbl.push_back(mk(3'b000, 0, 0, '0, '0, 3'b000, 3'b000, 0, 0, '0, '0, 0, 0, 0, 0));
      // Spurious beat in IDLE: acknowledged, dropped, flagged next cycle.
      tbl.push_back(mk(3'b000, 0, 1, 64'hDEAD, 13'h5, 3'b000, 3'b000, 0, 0, '0, '0, 0, 1, 0, 0));
      tbl.push_back(mk(3'b000, 0, 0, '0, '0, 3'b000, 3'b000, 0, 0, '0, '0, 0, 0, 0, 1));
      // Requester 1 again (rr=2 wraps to 1): 2-cycle hole after beat 3, bad tag on beat 5.
      tbl.push_back(mk(3'b010, 0, 0, '0, '0, 3'b010, 3'b000, 0, 0, '0, '0, 0, 0, 0, 1));
      tbl.push_back(mk(3'b000, 1, 0, '0, '0, 3'b000, 3'b000, 0, 1, A1, T1, 1, 0, 0, 1));
      for (int k = 1; k <= BPL; k++) begin
         if (k == 4) begin
            tbl.push_back(mk(3'b000, 0, 0, '0, '0, 3'b000, 3'b000, 0, 0, '0, '0, 1, 0, 0, 1));
            tbl.push_back(mk(3'b000, 0, 0, '0, '0, 3'b000, 3'b000, 0, 0, '0, '0, 1, 0, 0, 1));
         end
         tbl.push_back(mk(3'b000, 0, 1, DW'(k * 'h101), (k == 5) ? 13'h0042 : T1,
                          3'b000, 3'b010, k == BPL, 0, '0, '0, 1, 1, k > 5, 1));
      end
      tbl.push_back(mk(3'b000, 0, 0, '0, '0, 3'b000, 3'b000, 0, 0, '0, '0, 0, 0, 1, 1));

      rst_cyc();
      rst_cyc();
      cyc(mk(3'b000, 0, 0, '0, '0, 3'b000, 3'b000, 0, 0, '0, '0, 0, 0, 0, 0), "reset state");
      for (int i = 0; i < tbl.size(); i++) cyc(tbl[i], $sformatf("vec%0d", i));

      // Contention: all held; grants 0,1,2,0 each one cycle after resp_last.
      rst_cyc();
      run_txn(0, 3'b111, A0, T0);
      run_txn(1, 3'b111, A1, T1);
      run_txn(2, 3'b111, A2, T2);
      run_txn(0, 3'b111, A0, T0);

      // rr is now 1; requester 1 granted, reset after beat 4.
      cyc(mk(3'b010, 0, 0, '0, '0, 3'b010, 3'b000, 0, 0, '0, '0, 0, 0, 0, 0), "abort grant");
      cyc(mk(3'b000, 1, 0, '0, '0, 3'b000, 3'b000, 0, 1, A1, T1, 1, 0, 0, 0), "abort req");
      for (int k = 1; k <= 4; k++)
         cyc(mk(3'b000, 0, 1, DW'(k), T1, 3'b000, 3'b010, 0, 0, '0, '0, 1, 1, 0, 0), $sformatf("abort beat%0d", k));
      rst_cyc();
      // rr back to 0: with 0 and 2 pending, 0 must win.
      run_txn(0, 3'b101, A0, T0);
      run_txn(2, 3'b100, A2, T2);
      cyc(mk(3'b000, 0, 0, '0, '0, 3'b000, 3'b000, 0, 0, '0, '0, 0, 0, 0, 0), "final idle");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/sysbus_arbiter.md
# sysbus_arbiter

Round-robin arbiter and transaction sequencer that shares the single Sysbus master port of the core between internal read requesters: page-table walker, instruction fetch and data load. It sits between those units and the top-level `bus_*` ports. It grants one requester at a time and drives the request phase until `bus_reqack`. It then steers the 64-byte response burst back to the owner beat by beat, acknowledging each beat on the bus. Only one transaction is outstanding at a time; write transactions are out of scope.

## Interface
- BUS_DATA_WIDTH, 64, bus data/address width
- BUS_TAG_WIDTH, 13, Sysbus tag width
- NUM_REQ, 3, number of requesters; index 0 = page-table walker, 1 = instruction fetch, 2 = data load
- BEATS_PER_LINE, 8, response beats per transaction (64-byte line / 8-byte beat)

- clk  input  1  clock; already decided
- reset  input  1  reset, synchronous, active-high; already decided
- req_valid  input  NUM_REQ  per-requester request pending
- req_addr  input  NUM_REQ*BUS_DATA_WIDTH  packed physical addresses; slice i is requester i
- req_tag  input  NUM_REQ*BUS_TAG_WIDTH  packed request tags
- req_grant  output  NUM_REQ  one-hot, 1-cycle pulse: requester i's address/tag captured
- resp_valid  output  NUM_REQ  one-hot: resp_data holds a beat for that requester
- resp_data  output  BUS_DATA_WIDTH  response beat, shared by all requesters
- resp_last  output  1  current beat is the final beat of the burst
- busy  output  1  state != IDLE
- err_tag  output  1  sticky: resptag mismatch seen; cleared only by reset
- err_spurious  output  1  sticky: bus_respcyc outside RESP; cleared only by reset
- bus_reqcyc, bus_req, bus_reqtag  output  1/BUS_DATA_WIDTH/BUS_TAG_WIDTH  Sysbus request phase
- bus_reqack  input  1  Sysbus request accepted
- bus_respcyc, bus_resp, bus_resptag  input  1/BUS_DATA_WIDTH/BUS_TAG_WIDTH  Sysbus response beat
- bus_respack  output  1  Sysbus beat acknowledge

## Operation
- States: IDLE, REQ, RESP.
- **IDLE.** If any req_valid is set, pick winner w by round-robin, starting the search at pointer rr.
  - Pulse req_grant[w] combinationally in this cycle.
  - At the edge, latch owner=w, addr=req_addr[w], tag=req_tag[w]; go to REQ.
  - Requester may deassert req_valid after its grant.
- **REQ.** bus_reqcyc=1, bus_req=latched addr, bus_reqtag=latched tag, all held stable.
  - On the edge where bus_reqack=1: go to RESP, beat counter cnt=0.
- **RESP.**
  - bus_respack = bus_respcyc (combinational); every beat is consumed in the cycle it is presented.
  - resp_valid[owner] = bus_respcyc; resp_data = bus_resp.
  - resp_last = bus_respcyc && cnt==BEATS_PER_LINE-1.
  - Each beat increments cnt (width clog2(BEATS_PER_LINE)).
  - On the last beat: go to IDLE, rr = (owner+1) mod NUM_REQ.
- **Tag check.** In RESP, bus_respcyc && bus_resptag != latched tag sets err_tag. The beat is still delivered and counted.
- **Spurious response.** bus_respcyc in IDLE or REQ: acknowledge it (bus_respack=1), drop it (no resp_valid), set err_spurious.
- **Pointer.** rr advances only on transaction completion, never on grant.

## Timing
- Reset values:
  - state=IDLE, rr=0, cnt=0, latched owner/addr/tag=0.
  - All outputs 0: bus_reqcyc, bus_req, bus_reqtag, req_grant, resp_valid, resp_data, resp_last, busy, err_tag, err_spurious, bus_respack.
  - resp_data and bus_respack are combinational and are 0 whenever state=IDLE with no bus_respcyc.
- Grant latency: bus_reqcyc rises the cycle after req_grant.
  - Minimum transaction: 1 (IDLE) + 1 (REQ with same-cycle reqack) + BEATS_PER_LINE = 10 cycles.
- Back-to-back: IDLE lasts exactly one cycle between transactions when requests are pending.
  - The next grant is evaluated in the cycle after resp_last.
- Simultaneous bus_reqack and bus_respcyc in REQ: the beat is treated as spurious. Sysbus guarantees responses only after reqack.
- Gaps between beats (bus_respcyc=0 mid-burst): hold cnt, hold state, keep resp_valid=0.
- Reset mid-transaction abandons it immediately: no resp_last, rr=0, and bus_reqcyc=0 from the next cycle.

## Test plan
- Single requester: req_valid=3'b010, req_addr[1]=0x1000, tag=0x1100.
  - Expect req_grant=3'b010 in cycle 0, then bus_reqcyc=1 with bus_req=0x1000.
  - reqack arrives in cycle 3; 8 beats follow with 0x11..0x88.
  - Expect resp_valid=3'b010 on each beat, resp_last on 0x88, busy=0 afterwards.
- Contention: req_valid=3'b111 held throughout.
  - Grant order 0,1,2,0; each grant follows the previous resp_last by 1 cycle.
- Gapped burst: bus_respcyc has 2-cycle holes between beats 3 and 4.
  - Expect exactly 8 resp_valid pulses with resp_last only on the 8th beat.
- Tag mismatch: beat 5 carries resptag 0x0042 against latched tag 0x1100.
  - Expect err_tag=1 from the next cycle and the burst to complete normally.
- Spurious beat in IDLE.
  - Expect bus_respack=1, resp_valid=0, err_spurious=1.
- Reset asserted after beat 4.
  - Next cycle: state IDLE, all outputs 0, rr=0.
  - A new request from requester 2 is then granted normally.
